// File: rtl/seq_pkg.sv
// Shared types and constants for the multi-cycle addi/bne control sequencer.
package seq_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    WRITEBACK = 3'd3,
    HALT      = 3'd4
  } state_t;

  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [2:0] F3_ADDI   = 3'b000;
  localparam logic [2:0] F3_BNE    = 3'b001;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Instruction-fetch channel between the sequencer and instruction memory.
// Handshake: imem_req stays high for the whole FETCH state; a word is taken on
// every rising edge where imem_req and imem_valid are both 1, otherwise ignored.
interface multicycle_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_valid;

  modport master (output imem_req, input imem_rdata, input imem_valid);
  modport slave  (input imem_req, output imem_rdata, output imem_valid);
endinterface

// File: rtl/instr_decode.sv
// Combinational classifier for the latched instruction: addi, bne or illegal,
// plus the datapath controls each class needs.
module instr_decode
  import seq_pkg::*;
(
  input  logic [31:0] ir,
  output logic        is_addi,
  output logic        is_bne,
  output logic        illegal,
  output logic [2:0]  ALUctrl,
  output logic        ALUsrc,
  output logic        ImmSrc
);

  always_comb begin
    is_addi = (ir[6:0] == OP_IMM)    && (ir[14:12] == F3_ADDI);
    is_bne  = (ir[6:0] == OP_BRANCH) && (ir[14:12] == F3_BNE);
    illegal = !(is_addi || is_bne);
    ALUctrl = ALU_ADD;
    ALUsrc  = 1'b1;
    ImmSrc  = 1'b0;
    if (is_bne) begin
      ALUctrl = ALU_SUB;
      ALUsrc  = 1'b0;
      ImmSrc  = 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for the reduced addi/bne core;
// halts with a sticky fault code on an illegal instruction or fetch timeout.
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int FETCH_TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  multicycle_sequencer_if.master    imem,
  input  logic                      EQ,
  output logic [31:0]               ir,
  output logic                      RegWrite,
  output logic [2:0]                ALUctrl,
  output logic                      ALUsrc,
  output logic                      ImmSrc,
  output logic                      PCsrc,
  output logic                      PCen,
  output logic                      halted,
  output logic [1:0]                fault,
  output logic [CNT_W-1:0]          retired,
  output state_t                    dbg_state
);

  localparam int WAIT_W = $clog2(FETCH_TIMEOUT + 2);

  state_t            state;
  logic              eq_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              req_q;

  logic       dec_addi, dec_bne, dec_illegal;
  logic [2:0] dec_aluctrl;
  logic       dec_alusrc, dec_immsrc;

  instr_decode u_decode (
    .ir      (ir),
    .is_addi (dec_addi),
    .is_bne  (dec_bne),
    .illegal (dec_illegal),
    .ALUctrl (dec_aluctrl),
    .ALUsrc  (dec_alusrc),
    .ImmSrc  (dec_immsrc)
  );

  // Strobes are registered on the transition into the state that owns them,
  // so they are pure functions of state/ir/eq_q with no input-to-output path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      ir       <= '0;
      eq_q     <= 1'b0;
      wait_cnt <= '0;
      retired  <= '0;
      fault    <= FAULT_NONE;
      halted   <= 1'b0;
      req_q    <= 1'b1;
      RegWrite <= 1'b0;
      PCen     <= 1'b0;
      PCsrc    <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem.imem_valid) begin
            ir       <= imem.imem_rdata;
            wait_cnt <= '0;
            req_q    <= 1'b0;
            state    <= DECODE;
          end else if (wait_cnt == WAIT_W'(FETCH_TIMEOUT)) begin
            req_q  <= 1'b0;
            halted <= 1'b1;
            fault  <= FAULT_TIMEOUT;
            state  <= HALT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DECODE: begin
          if (dec_illegal) begin
            halted <= 1'b1;
            fault  <= FAULT_ILLEGAL;
            state  <= HALT;
          end else begin
            state <= EXECUTE;
          end
        end
        EXECUTE: begin
          eq_q     <= EQ;
          RegWrite <= dec_addi;
          PCen     <= 1'b1;
          PCsrc    <= dec_bne & ~EQ;
          state    <= WRITEBACK;
        end
        WRITEBACK: begin
          retired  <= retired + 1'b1;
          RegWrite <= 1'b0;
          PCen     <= 1'b0;
          PCsrc    <= 1'b0;
          req_q    <= 1'b1;
          state    <= FETCH;
        end
        default: begin
          state    <= HALT;
          req_q    <= 1'b0;
          RegWrite <= 1'b0;
          PCen     <= 1'b0;
          PCsrc    <= 1'b0;
        end
      endcase
    end
  end

  // ir still holds the previous instruction during FETCH, so gate the decoded
  // controls to the phases that actually use the current instruction.
  always_comb begin
    ALUctrl = ALU_ADD;
    ALUsrc  = 1'b1;
    ImmSrc  = 1'b0;
    if (state == DECODE || state == EXECUTE || state == WRITEBACK) begin
      ALUctrl = dec_aluctrl;
      ALUsrc  = dec_alusrc;
      ImmSrc  = dec_immsrc;
    end
  end

  assign imem.imem_req = req_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer (CNT_W=2, FETCH_TIMEOUT=4).
module tb_multicycle_sequencer;
  import seq_pkg::*;

  localparam logic [31:0] I_ADDI    = 32'h00500093;
  localparam logic [31:0] I_BNE     = 32'h00209463;
  localparam logic [31:0] I_ILLEGAL = 32'h00000033;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       eq  = 1'b0;
  logic [31:0] ir;
  logic       reg_write, alu_src, imm_src, pc_src, pc_en, halted;
  logic [2:0] alu_ctrl;
  logic [1:0] fault;
  logic [1:0] retired;
  state_t     dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_sequencer_if bus ();

  multicycle_sequencer #(.CNT_W(2), .FETCH_TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .imem      (bus.master),
    .EQ        (eq),
    .ir        (ir),
    .RegWrite  (reg_write),
    .ALUctrl   (alu_ctrl),
    .ALUsrc    (alu_src),
    .ImmSrc    (imm_src),
    .PCsrc     (pc_src),
    .PCen      (pc_en),
    .halted    (halted),
    .fault     (fault),
    .retired   (retired),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.imem_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Offer one word in FETCH and step onto the fetch edge (now in DECODE).
  task automatic fetch(input logic [31:0] word);
    bus.imem_rdata = word;
    bus.imem_valid = 1'b1;
    step();
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 32'hdeadbeef;
  endtask

  initial begin
    bus.imem_valid = 1'b0;
    bus.imem_rdata = '0;

    // Reset state
    do_reset();
    check("rst_state", 32'(dbg_state), 32'(FETCH));
    check("rst_req", 32'(bus.imem_req), 32'd1);
    check("rst_alusrc", 32'(alu_src), 32'd1);
    check("rst_ir", ir, 32'd0);
    check("rst_misc", {reg_write, pc_en, pc_src, imm_src, halted, alu_ctrl, fault, retired},
          32'd0);

    // addi x1,x0,5
    fetch(I_ADDI);
    check("addi_dec_state", 32'(dbg_state), 32'(DECODE));
    check("addi_ir", ir, I_ADDI);
    check("addi_dec_req", 32'(bus.imem_req), 32'd0);
    check("addi_dec_strobes", {reg_write, pc_en}, 32'd0);
    step();
    check("addi_ex_strobes", {reg_write, pc_en}, 32'd0);
    check("addi_ex_ctrl", {alu_ctrl, alu_src, imm_src}, {27'd0, 3'b000, 1'b1, 1'b0});
    step();
    check("addi_wb_state", 32'(dbg_state), 32'(WRITEBACK));
    check("addi_wb_strobes", {reg_write, pc_en, pc_src}, 32'b110);
    check("addi_wb_alusrc", 32'(alu_src), 32'd1);
    step();
    check("addi_done_regwrite", 32'(reg_write), 32'd0);
    check("addi_retired", 32'(retired), 32'd1);
    check("addi_back_fetch", {bus.imem_req, 3'(dbg_state)}, {28'd0, 1'b1, 3'(FETCH)});

    // bne not taken vs taken
    for (int k = 0; k < 2; k++) begin
      fetch(I_BNE);
      check("bne_dec_ctrl", {alu_ctrl, alu_src, imm_src}, {27'd0, 3'b001, 1'b0, 1'b1});
      eq = (k == 1);
      step();
      check("bne_ex_ctrl", {alu_ctrl, alu_src, imm_src}, {27'd0, 3'b001, 1'b0, 1'b1});
      step();
      eq = ~eq;
      check("bne_wb_regwrite", 32'(reg_write), 32'd0);
      check("bne_wb_pcen", 32'(pc_en), 32'd1);
      check("bne_wb_pcsrc", 32'(pc_src), (k == 0) ? 32'd1 : 32'd0);
      check("bne_wb_ctrl", {alu_ctrl, alu_src, imm_src}, {27'd0, 3'b001, 1'b0, 1'b1});
      step();
      check("bne_retired", 32'(retired), 32'(k + 2));
      check("bne_fetch_ctrl", {alu_ctrl, alu_src, imm_src, pc_en}, {27'd0, 3'b000, 1'b1, 1'b0, 1'b0});
    end
    eq = 1'b0;

    // Illegal instruction halts after DECODE and ignores imem thereafter
    fetch(I_ILLEGAL);
    check("ill_dec_state", 32'(dbg_state), 32'(DECODE));
    step();
    check("ill_halt_state", 32'(dbg_state), 32'(HALT));
    check("ill_halted", {halted, fault}, {29'd0, 1'b1, 2'b01});
    bus.imem_valid = 1'b1;
    bus.imem_rdata = I_ADDI;
    for (int c = 0; c < 20; c++) begin
      step();
      check("ill_hold", {bus.imem_req, reg_write, pc_en, halted, fault, 3'(dbg_state)},
            {22'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 3'(HALT)});
    end
    check("ill_ir_kept", ir, I_ILLEGAL);

    // Fetch timeout: 4 waiting cycles survive, the 5th halts
    do_reset();
    for (int c = 0; c < 4; c++) begin
      step();
      check("to_waiting", {halted, bus.imem_req, 3'(dbg_state)}, {27'd0, 1'b0, 1'b1, 3'(FETCH)});
    end
    step();
    check("to_halted", {halted, fault, bus.imem_req}, {28'd0, 1'b1, 2'b10, 1'b0});
    check("to_state", 32'(dbg_state), 32'(HALT));

    // Valid in the timeout cycle wins
    do_reset();
    repeat (4) step();
    fetch(I_ADDI);
    check("to_accept_state", 32'(dbg_state), 32'(DECODE));
    check("to_accept_fault", {halted, fault}, 32'd0);
    check("to_accept_ir", ir, I_ADDI);

    // Reset during WRITEBACK aborts the instruction
    do_reset();
    fetch(I_ADDI);
    step();
    step();
    check("rwb_in_wb", {reg_write, pc_en, 3'(dbg_state)}, {27'd0, 1'b1, 1'b1, 3'(WRITEBACK)});
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rwb_retired", 32'(retired), 32'd0);
    check("rwb_fetch", {bus.imem_req, reg_write, pc_en, 3'(dbg_state)},
          {26'd0, 1'b1, 1'b0, 1'b0, 3'(FETCH)});
    check("rwb_ir", ir, 32'd0);

    // Retired counter wraps modulo 4: 1,2,3,0,1
    for (int n = 1; n <= 5; n++) begin
      fetch(I_ADDI);
      step();
      step();
      step();
      check("wrap_retired", 32'(retired), 32'(n % 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle control sequencer for the reduced RISC-V core (addi, bne). It fetches each instruction from instruction memory over a valid handshake and latches it into an instruction register. It then steps the shared datapath through fixed decode, execute and writeback phases, driving the ALU, immediate, register-file and PC-update controls. It replaces purely combinational per-instruction control in the top level, and it halts with a fault code on an illegal instruction or a fetch timeout.

## Interface
Parameters:
- CNT_W, 16: width of the retired-instruction counter.
- FETCH_TIMEOUT, 255: maximum number of FETCH cycles without imem_valid before a timeout fault.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_rdata  in  32  instruction word; sampled only when imem_valid=1 in FETCH.
- imem_valid  in  1  instruction-memory response valid.
- EQ  in  1  ALU equality flag from the datapath.
- imem_req  out  1  fetch request; high in FETCH only.
- ir  out  32  latched instruction register.
- RegWrite  out  1  register-file write strobe.
- ALUctrl  out  3  ALU operation.
- ALUsrc  out  1  ALU B operand select: 1 = immediate, 0 = register.
- ImmSrc  out  1  immediate format select: 0 = I-type, 1 = B-type.
- PCsrc  out  1  PC next select: 1 = branch target, 0 = PC+4.
- PCen  out  1  PC update strobe.
- halted  out  1  sticky halt indicator.
- fault  out  2  halt cause: 00 none, 01 illegal instruction, 10 fetch timeout.
- retired  out  CNT_W  count of completed instructions.

## Operation
- States: FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- FETCH:
  - imem_req=1.
  - If imem_valid=1: ir<=imem_rdata, wait counter cleared, go to DECODE.
  - Otherwise the wait counter increments. When the counter reaches FETCH_TIMEOUT, go to HALT with fault=10.
- DECODE: classify ir.
  - addi: opcode 7'h13, funct3 000.
  - bne: opcode 7'h63, funct3 001.
  - Either class: go to EXECUTE.
  - Anything else: go to HALT with fault=01.
- EXECUTE:
  - Datapath controls are driven from the decoded ir.
  - EQ is registered into eq_q at the end of this cycle.
  - Next state is WRITEBACK.
- WRITEBACK:
  - PCen=1.
  - addi: RegWrite=1, PCsrc=0.
  - bne: RegWrite=0, PCsrc=~eq_q.
  - retired increments, wrapping modulo 2^CNT_W.
  - Next state is FETCH.
- HALT:
  - Absorbing state; only rst leaves it.
  - halted=1, fault holds its cause, all strobes are 0, imem_req=0.
- Control values, held identical in DECODE, EXECUTE and WRITEBACK:
  - addi: ALUctrl=000, ALUsrc=1, ImmSrc=0.
  - bne: ALUctrl=001, ALUsrc=0, ImmSrc=1.
  - FETCH, HALT, or an unclassified ir: ALUctrl=000, ALUsrc=1, ImmSrc=0.
- RegWrite and PCen are high only in WRITEBACK. They are never high in any other state.
- imem_valid outside FETCH is ignored, and imem_rdata is not sampled.

## Timing
- Reset: on a clock edge with rst=1, the block loads state=FETCH, ir=0, eq_q=0, wait counter=0, retired=0, fault=00, halted=0.
- Output values in the cycle after that reset edge:
  - imem_req=1, ALUsrc=1.
  - All other outputs are 0.
- rst takes priority over every transition. Reset asserted mid-instruction (including in WRITEBACK or HALT) aborts the instruction: no RegWrite, PCen or retired update occurs on that edge.
- Outputs are Moore functions of state and ir (plus eq_q for PCsrc). There is no combinational path from EQ or imem_valid to any output.
- Latency:
  - An instruction whose imem_valid arrives in its first FETCH cycle takes 4 cycles, from FETCH entry to the cycle after WRITEBACK.
  - Each additional wait cycle in FETCH adds 1 cycle.
- Timeout: with imem_valid held low, HALT is entered on the edge ending FETCH cycle number FETCH_TIMEOUT+1.
- If imem_valid=1 arrives in the same cycle the timeout is reached, the fetch is accepted and no fault is raised.
- retired wraps from 2^CNT_W−1 to 0 with no flag.

## Structure
- Package seq_pkg holds:
  - the state enum (FETCH, DECODE, EXECUTE, WRITEBACK, HALT);
  - opcode constants OP_IMM=7'h13 and OP_BRANCH=7'h63;
  - funct3 constants F3_ADDI=3'b000 and F3_BNE=3'b001;
  - the ALUctrl encodings;
  - the fault codes.
- Sub-module instr_decode, purely combinational:
  - input: ir;
  - outputs: is_addi, is_bne, illegal, ALUctrl, ALUsrc, ImmSrc.
- The sequencer itself holds the FSM, eq_q, the wait counter and the retired counter.

## Test plan
- addi: imem_valid=1 immediately with ir=32'h00500093 (addi x1,x0,5).
  - Required: RegWrite=1 for exactly 1 cycle, 3 cycles after the fetch edge; PCen=1 with PCsrc=0; ALUsrc=1; retired=1.
- bne taken vs. not taken: ir=32'h00209463 (bne x1,x2,8).
  - EQ=0 in EXECUTE: PCsrc=1, PCen=1, RegWrite=0, ALUsrc=0, ImmSrc=1, ALUctrl=001.
  - EQ=1 in EXECUTE: PCsrc=0.
- Illegal instruction: ir=32'h00000033 (R-type).
  - Required: HALT on the edge after DECODE; halted=1, fault=01; imem_req stays 0 for 20 further cycles.
- Fetch timeout: FETCH_TIMEOUT=4, imem_valid held 0.
  - Required: halted=1, fault=10 after 5 FETCH cycles.
  - Variant: imem_valid=1 in FETCH cycle 5 is accepted with no fault.
- Reset mid-WRITEBACK:
  - Required: retired unchanged, then state=FETCH, imem_req=1, ir=0.
  - Rerun with CNT_W=2: 5 addi instructions give retired sequence 1,2,3,0,1.
